// File: rtl/tempsens_serial_reader.sv
// rtl/tempsens_serial_reader.sv - serial temperature sensor reader: cs_n/sclk generation, MSB-first capture
module tempsens_serial_reader #(
    parameter int DIV_HALF = 135000,
    parameter int CNT_W    = 28,
    parameter int NBITS    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sdata,
    output logic             sclk,
    output logic             cs_n,
    output logic [NBITS-1:0] temp_data,
    output logic             data_valid,
    output logic             busy
);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NBITS-1:0]   shift_reg;
    logic [1:0]         sync;
    logic               tick;
    logic               sclk_nx;
    logic               cs_n_nx;
    logic               capture;
    logic               load;

    assign tick = (state != IDLE) && (tick_cnt == CNT_W'(DIV_HALF));
    assign busy = (state != IDLE) || data_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sclk_nx  = sclk;
        cs_n_nx  = cs_n;
        capture  = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                    cs_n_nx  = 1'b0;
                end
            end
            SETUP: begin
                // The setup tick doubles as the rising edge for the first (MSB) bit.
                if (tick) begin
                    state_nx = SHIFT;
                    sclk_nx  = 1'b1;
                    capture  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk) begin
                        sclk_nx = 1'b0;
                        if (bit_cnt == BW'(NBITS)) begin
                            state_nx = HOLD;
                        end
                    end else begin
                        sclk_nx = 1'b1;
                        capture = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_nx = DONE;
                    cs_n_nx  = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                load     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            temp_data  <= '0;
            data_valid <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            sync       <= '0;
        end else begin
            sclk       <= sclk_nx;
            cs_n       <= cs_n_nx;
            data_valid <= load;
            sync       <= {sync[0], sdata};

            // Every phase is timed from its own entry, so the counter restarts on any state change.
            if (state == IDLE || state_nx != state || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (capture) begin
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (capture) begin
                shift_reg <= {shift_reg[NBITS-2:0], sync[1]};
            end

            if (load) begin
                temp_data <= shift_reg;
            end
        end
    end
endmodule
